mem_stage_sram: RTL and testbench

Parametrised data-memory block for the MEM stage of the pipelined ARM core. It models a word-organised SRAM with a fixed number of wait states, byte-lane write enables and a registered read port. A `ready` handshake lets the hazard/freeze logic stall the pipeline while an access is in flight.

---
 rtl/mem_stage_sram.sv | 109 ++++++++++
 tb/tb_mem_stage_sram.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage_sram.sv
// Word-organised data SRAM for the MEM stage: fixed wait states, byte-lane writes, registered read port.
// Define MEM_RESET_INIT_EN to have reset load word i with value i (simulation only).
module mem_stage_sram #(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 16,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                wr_en,
  input  logic                rd_en,
  input  logic [31:0]         address,
  input  logic [DATA_W-1:0]   input_data,
  input  logic [DATA_W/8-1:0] byte_en,
  output logic [DATA_W-1:0]   data,
  output logic                ready,
  output logic [1:0]          dbg_state
);

  localparam int NB    = DATA_W / 8;
  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t              r_state;
  logic [3:0]          r_cnt;
  logic [DATA_W-1:0]   r_data;
  logic [DATA_W-1:0]   r_mem [DEPTH];

  logic                w_req;
  logic [ADDR_W-1:0]   w_idx;
  logic                w_finish;
  logic                w_commit_wr;
  logic [DATA_W-1:0]   w_mask;
  logic [DATA_W-1:0]   w_wr_word;
  logic                w_unused_addr;

  // Handshake: the requester holds req and its operands stable from the IDLE
  // request cycle through DONE; ready low means the pipeline must freeze.
  assign w_req         = wr_en | rd_en;
  assign w_idx         = address[ADDR_W+1:2];
  assign w_unused_addr = ^{address[31:ADDR_W+2], address[1:0]};
  assign w_finish      = (r_state == S_BUSY) && w_req && (r_cnt == 4'd0);
  assign w_commit_wr   = w_finish && wr_en;

  always_comb begin
    w_mask = '0;
    for (int k = 0; k < NB; k++) w_mask[8*k +: 8] = {8{byte_en[k]}};
  end

  assign w_wr_word = (r_mem[w_idx] & ~w_mask) | (input_data & w_mask);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
      r_data  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_req) begin
            r_state <= S_BUSY;
            r_cnt   <= 4'(WAIT_CYCLES - 1);
          end
        end
        S_BUSY: begin
          if (!w_req) begin
            r_state <= S_IDLE;
          end else if (r_cnt == 4'd0) begin
            r_state <= S_DONE;
            // A combined read+write is treated as a write and returns zero.
            r_data  <= wr_en ? '0 : r_mem[w_idx];
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_data  <= '0;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef MEM_RESET_INIT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= DATA_W'(i);
    end else if (w_commit_wr) begin
      r_mem[w_idx] <= w_wr_word;
    end
  end
`else
  // No reset on the array so it maps onto a plain SRAM macro.
  always_ff @(posedge clk) begin
    if (w_commit_wr) r_mem[w_idx] <= w_wr_word;
  end
`endif

  assign data      = r_data;
  assign ready     = ((r_state == S_IDLE) && !w_req) || (r_state == S_DONE);
  assign dbg_state = r_state;

endmodule

// File: tb/tb_mem_stage_sram.sv
// Bench for mem_stage_sram: directed cases plus random traffic, checked against a word-map model.
module tb_mem_stage_sram;

  localparam int W    = 32;
  localparam int WAIT = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          wr_en, rd_en;
  logic [31:0]   address;
  logic [W-1:0]  input_data;
  logic [3:0]    byte_en;
  logic [W-1:0]  data, b_data;
  logic          ready, b_ready;
  logic [1:0]    dbg_state, b_state;

  int            checks = 0;
  int            errors = 0;
  logic [W-1:0]  exp_q[$];
  logic [W-1:0]  model_m [int];
  logic          chk_b = 1'b0;
  logic [W-1:0]  exp_b = '0;

  mem_stage_sram #(.DATA_W(W), .ADDR_W(16), .WAIT_CYCLES(WAIT)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .rd_en(rd_en), .address(address),
    .input_data(input_data), .byte_en(byte_en), .data(data), .ready(ready),
    .dbg_state(dbg_state)
  );

  mem_stage_sram #(.DATA_W(W), .ADDR_W(4), .WAIT_CYCLES(WAIT)) dut_b (
    .clk(clk), .rst(rst), .wr_en(wr_en), .rd_en(rd_en), .address(address),
    .input_data(input_data), .byte_en(byte_en), .data(b_data), .ready(b_ready),
    .dbg_state(b_state)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // reference model: 16-bit word index, byte-merged writes
  function automatic int widx(input logic [31:0] a);
    return int'(a[17:2]);
  endfunction

  function automatic logic [W-1:0] model_read(input int idx);
    if (model_m.exists(idx)) return model_m[idx];
`ifdef MEM_RESET_INIT_EN
    return W'(idx);
`else
    return '0;
`endif
  endfunction

  function automatic bit model_known(input int idx);
`ifdef MEM_RESET_INIT_EN
    return 1'b1;
`else
    return model_m.exists(idx);
`endif
  endfunction

  task automatic model_write(input int idx, input logic [W-1:0] d, input logic [3:0] be);
    logic [W-1:0] cur;
    cur = model_read(idx);
    for (int k = 0; k < 4; k++)
      if (be[k]) cur[8*k +: 8] = d[8*k +: 8];
    model_m[idx] = cur;
  endtask

  // driver: entered just after a rising edge with the DUT idle, leaves the same way
  task automatic access(input logic w, input logic r, input logic [31:0] a,
                        input logic [W-1:0] d, input logic [3:0] be);
    int stall;
    wr_en = w; rd_en = r; address = a; input_data = d; byte_en = be;
    exp_q.push_back(w ? '0 : model_read(widx(a)));
    if (w) model_write(widx(a), d, be);
    stall = 0;
    forever begin
      @(negedge clk);
      if (ready) break;
      stall++;
      if (stall > 40) break;
    end
    check("stall_cycles", W'(stall), W'(WAIT + 1));
    @(posedge clk); #1;
    wr_en = 1'b0; rd_en = 1'b0;
    check("data_cleared", data, '0);
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check("idle_ready", W'(ready), W'(1));
      @(posedge clk); #1;
    end
  endtask

  // monitor / scoreboard
  always @(negedge clk) begin
    if (!rst && ready && (wr_en || rd_en)) begin
      if (exp_q.size() == 0) begin
        check("unexpected_done", W'(1), W'(0));
      end else begin
        check("done_data", data, exp_q.pop_front());
      end
      if (chk_b) check("alias_data", b_data, exp_b);
    end
  end

  initial begin
    int idx;
    logic [31:0] a;
    logic w, r;
    rst = 1'b1; wr_en = 0; rd_en = 0; address = '0; input_data = '0; byte_en = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_ready", W'(ready), W'(1));
    check("rst_data", data, '0);
    check("rst_state", W'(dbg_state), W'(0));
    check("rst_b_ready", W'(b_ready), W'(1));
    @(posedge clk); #1;

`ifndef MEM_RESET_INIT_EN
    access(1, 0, 32'h0000_0010, 32'h0000_0004, 4'hF);
`endif
    access(0, 1, 32'h0000_0010, '0, 4'h0);

    access(1, 0, 32'h0000_0040, 32'hDEAD_BEEF, 4'b1111);
    access(1, 0, 32'h0000_0040, 32'h0000_1100, 4'b0010);
    access(0, 1, 32'h0000_0040, '0, 4'h0);
    access(1, 0, 32'h0000_0040, 32'hFFFF_FFFF, 4'b0000);
    access(0, 1, 32'h0000_0042, '0, 4'h0);

    access(1, 1, 32'h0000_0080, 32'h1234_5678, 4'hF);
    access(0, 1, 32'h0000_0080, '0, 4'h0);

    // abort a write in its second BUSY cycle
    access(1, 0, 32'h0000_0100, 32'h0BAD_F00D, 4'hF);
    wr_en = 1; address = 32'h0000_0100; input_data = 32'hAAAA_AAAA; byte_en = 4'hF;
    @(posedge clk); #1;
    @(posedge clk); #1;
    wr_en = 0;
    @(negedge clk);
    check("abort_busy_state", W'(dbg_state), W'(1));
    @(posedge clk); #1;
    check("abort_state", W'(dbg_state), W'(0));
    check("abort_ready", W'(ready), W'(1));
    check("abort_data", data, '0);
    access(0, 1, 32'h0000_0100, '0, 4'h0);

    // reset in the middle of a write
    access(1, 0, 32'h0000_0200, 32'h1111_2222, 4'hF);
    wr_en = 1; address = 32'h0000_0200; input_data = 32'hFFFF_0000; byte_en = 4'hF;
    @(posedge clk); #1;
    rst = 1'b1; wr_en = 0;
    #1;
    check("midrst_ready", W'(ready), W'(1));
    check("midrst_data", data, '0);
    check("midrst_state", W'(dbg_state), W'(0));
    @(negedge clk);
    rst = 1'b0;
`ifdef MEM_RESET_INIT_EN
    model_m.delete();
`endif
    @(posedge clk); #1;
    access(0, 1, 32'h0000_0200, '0, 4'h0);

    // aliasing in the 16-word instance
    access(1, 0, 32'h0000_0004, 32'h0000_0011, 4'hF);
    access(1, 0, 32'h0000_0044, 32'h0000_0055, 4'hF);
    exp_b = 32'h0000_0055; chk_b = 1'b1;
    access(0, 1, 32'h0000_0004, '0, 4'h0);
    chk_b = 1'b0;

    // wrap of the 16-bit index in the main instance
    access(1, 0, 32'hABC4_0044, 32'h7777_8888, 4'hF);
    access(0, 1, 32'h0000_0047, '0, 4'h0);

    // random traffic, back-to-back or with short gaps
    for (int n = 0; n < 80; n++) begin
      idx = 32'h300 + $urandom_range(0, 7) * 37;
      a = ($urandom & 32'hFFFC_0000) | (32'(idx) << 2) | 32'($urandom_range(0, 3));
      case ($urandom_range(0, 3))
        0, 1: begin w = 0; r = 1; end
        2: begin w = 1; r = 0; end
        default: begin w = 1; r = 1; end
      endcase
      if (!w && !model_known(idx)) w = 1;
      access(w, r, a, $urandom, 4'($urandom_range(0, 15)));
      if ($urandom_range(0, 2) == 0) idle_cycles($urandom_range(1, 2));
    end

    idle_cycles(2);
    check("queue_drained", W'(exp_q.size()), W'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
